tt06_mithro_lut4_test: RTL and testbench

TT06_MITHRO_LUT4_TEST -- requirements
Module: tt06_mithro_lut4_test

---
 rtl/tt06_mithro_lut4_test.sv | 74 +++++++
 tb/tb_tt06_mithro_lut4_test.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/tt06_mithro_lut4_test.sv
// Four LUT4 cells fed by one 64-bit serial config chain, with combinational and registered outputs.
// Optional readback of the chain tail on uio_out[2] when LUT4_READBACK_EN is defined.
module lut4_cell (
    input  logic [15:0] tbl,
    input  logic [3:0]  addr,
    output logic        y
);
    assign y = tbl[addr];
endmodule

module tt06_mithro_lut4_test (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam int NUM_LUTS = 4;
    localparam int CW       = NUM_LUTS * 16;

    typedef struct packed {
        logic cfg;
        logic sh;
        logic din;
    } cfg_req_t;

    cfg_req_t                     req;
    logic [CW-1:0]                cfg_chain;
    logic [NUM_LUTS-1:0][3:0]     lut_addr;
    logic [NUM_LUTS-1:0]          lut_y;
    logic [NUM_LUTS-1:0]          lut_q;
    logic                         unused_ok;

    assign req       = '{cfg: uio_in[7], sh: uio_in[1], din: uio_in[0]};
    assign unused_ok = ^uio_in[6:2];

    // Lower half of the LUTs share address A, upper half share address B.
    for (genvar k = 0; k < NUM_LUTS; k++) begin : g_lut
        assign lut_addr[k] = (k < NUM_LUTS/2) ? ui_in[3:0] : ui_in[7:4];
        lut4_cell u_lut (
            .tbl  (cfg_chain[16*k +: 16]),
            .addr (lut_addr[k]),
            .y    (lut_y[k])
        );
    end

    // First bit shifted in ends up in the MSB after a full load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cfg_chain <= '0;
        else if (ena && req.cfg && req.sh)
            cfg_chain <= {cfg_chain[CW-2:0], req.din};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lut_q <= '0;
        else if (ena && !req.cfg)
            lut_q <= lut_y;
    end

    assign uo_out = {lut_q, lut_y};

`ifdef LUT4_READBACK_EN
    assign uio_out = {5'b0, cfg_chain[CW-1], 2'b0};
    assign uio_oe  = 8'h04;
`else
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;
`endif
endmodule

// File: tb/tb_tt06_mithro_lut4_test.sv
// Directed bench for tt06_mithro_lut4_test: reset, loads, LUT sweeps, hold, shift overflow, mid-load reset, readback.
module tb_tt06_mithro_lut4_test;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks = 0;
    int errors = 0;

`ifdef LUT4_READBACK_EN
    localparam logic [7:0] OE_EXP = 8'h04;
`else
    localparam logic [7:0] OE_EXP = 8'h00;
`endif

    tt06_mithro_lut4_test dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
        .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_bit(input logic b);
        ena = 1'b1;
        uio_in = {1'b1, 5'b0, 1'b1, b};
        tick();
    endtask

    task automatic load(input logic [63:0] p);
        for (int i = 63; i >= 0; i--) shift_bit(p[i]);
        uio_in = 8'h00;
    endtask

    // Reconstructs the chain by sweeping both address nibbles; cfg must be 0.
    task automatic read_c(output logic [63:0] c);
        c = '0;
        for (int a = 0; a < 16; a++) begin
            ui_in = {a[3:0], a[3:0]};
            #1;
            c[a]      = uo_out[0];
            c[16 + a] = uo_out[1];
            c[32 + a] = uo_out[2];
            c[48 + a] = uo_out[3];
        end
    endtask

    logic [63:0] c_rd;
    logic [63:0] pat;

    initial begin
        // reset with arbitrary inputs
        ena = 1'b1; ui_in = 8'hA5; uio_in = 8'h83;
        #12;
        chk("rst_uo", {56'b0, uo_out}, 64'h00);
        chk("rst_uio", {56'b0, uio_out}, 64'h00);
        chk("rst_oe", {56'b0, uio_oe}, {56'b0, OE_EXP});
        @(negedge clk);
        rst_n = 1'b1;
        uio_in = 8'h00;
        tick();

        // 0x8000 in every LUT: output 1 only at address 15
        load({4{16'h8000}});
        ui_in = 8'hFF; #1;
        chk("and_ff_comb", {60'b0, uo_out[3:0]}, 64'hF);
        ui_in = 8'hF0; #1;
        chk("and_f0_comb", {60'b0, uo_out[3:0]}, 64'hC);
        tick();
        chk("and_f0_reg", {60'b0, uo_out[7:4]}, 64'hC);
        ui_in = 8'h0F; #1;
        chk("and_0f_comb", {60'b0, uo_out[3:0]}, 64'h3);
        chk("and_0f_reg_pre", {60'b0, uo_out[7:4]}, 64'hC);
        tick();
        chk("and_0f_reg", {60'b0, uo_out[7:4]}, 64'h3);

        // XOR4 in LUT0, others zero
        load({48'h0, 16'h6996});
        for (int a = 0; a < 16; a++) begin
            ui_in = {4'h0, a[3:0]}; #1;
            chk($sformatf("xor_a%0d", a), {60'b0, uo_out[3:0]}, {63'b0, ^a[3:0]});
        end

        // hold with ena=0, then with sh=0, then with cfg dropping on the shift edge
        pat = {48'h0, 16'h6996};
        for (int i = 0; i < 20; i++) begin
            ena = 1'b0; uio_in = {1'b1, 5'b0, 1'b1, i[0]}; tick();
        end
        uio_in = 8'h00;
        read_c(c_rd);
        chk("hold_ena0", c_rd, pat);
        for (int i = 0; i < 20; i++) begin
            ena = 1'b1; uio_in = {1'b1, 5'b0, 1'b0, i[0]}; tick();
        end
        uio_in = 8'h00;
        read_c(c_rd);
        chk("hold_sh0", c_rd, pat);
        ena = 1'b1; uio_in = 8'h03; tick();
        uio_in = 8'h00;
        read_c(c_rd);
        chk("hold_cfg0", c_rd, pat);

        // registered outputs hold while ena=0
        ena = 1'b1; ui_in = 8'h01; tick();
        chk("reg_capture", {60'b0, uo_out[7:4]}, 64'h1);
        ena = 1'b0; ui_in = 8'h00;
        tick(); tick(); tick();
        chk("reg_hold", {60'b0, uo_out[7:4]}, 64'h1);
        chk("comb_track", {63'b0, uo_out[0]}, 64'h0);

        // arbitrary pattern, then 4 extra shifts push out the top nibble
        pat = 64'hDEAD_BEEF_0123_CAFE;
        load(pat);
        read_c(c_rd);
        chk("load_pat", c_rd, pat);
        shift_bit(1'b1); shift_bit(1'b0); shift_bit(1'b1); shift_bit(1'b0);
        uio_in = 8'h00;
        read_c(c_rd);
        chk("overflow", c_rd, {pat[59:0], 4'b1010});

        // registered outputs nonzero, then reset in the middle of a load
        ena = 1'b1; ui_in = 8'hFF; tick();
        for (int i = 0; i < 30; i++) shift_bit(1'b1);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_uo", {56'b0, uo_out}, 64'h00);
        chk("midrst_uio", {56'b0, uio_out}, 64'h00);
        #2 rst_n = 1'b1;
        uio_in = 8'h00;
        tick();
        read_c(c_rd);
        chk("midrst_c", c_rd, 64'h0);
        pat = 64'h0123_4567_89AB_CDEF;
        load(pat);
        read_c(c_rd);
        chk("reload", c_rd, pat);

`ifdef LUT4_READBACK_EN
        pat = 64'hF0E1_D2C3_B4A5_9687;
        load(pat);
        for (int i = 0; i < 64; i++) begin
            chk($sformatf("rb_bit%0d", i), {63'b0, uio_out[2]}, {63'b0, pat[63 - i]});
            shift_bit(1'b0);
        end
        uio_in = 8'h00;
        read_c(c_rd);
        chk("rb_clear", c_rd, 64'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
